// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, memory-stage FSM states and
// writeback control encodings.
package cpu_pkg;

  parameter int DATA_W     = 16;
  parameter int REG_ADDR_W = 3;
  parameter int CPSR_W     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // WB_BUBBLE marks "nothing to write back"; the others select the writeback source.
  localparam logic [1:0] WB_BUBBLE = 2'b00;
  localparam logic [1:0] WB_ALU    = 2'b01;
  localparam logic [1:0] WB_LOAD   = 2'b10;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave):
// req/gnt request handshake followed by an rvalid read-data return.
interface mem_stage_if;
  import cpu_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Outstanding-access watchdog: counts cycles while an access is in flight and
// flags the cycle on which the count reaches TIMEOUT_CYCLES-1.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Held at zero while idle, so every new access starts counting from zero.
  always_comb begin
    cnt_d = '0;
    if (busy_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = busy_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: issues loads/stores on the data-memory bus,
// stalls upstream while an access is outstanding, and registers results toward
// MEM/WB. Define MEM_TIMEOUT_EN to abort accesses that exceed TIMEOUT_CYCLES.
module mem_stage
  import cpu_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     rs2_data_in,
  input  logic                  ctrl_MEM_read_in,
  input  logic                  ctrl_MEM_write_in,
  input  logic [1:0]            ctrl_WB_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic [CPSR_W-1:0]     alu_cpsr_in,
  output logic                  stall_out,
  mem_stage_if.master           dmem,
  output logic [DATA_W-1:0]     wb_data_out,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_out,
  output logic [1:0]            ctrl_WB_out,
  output logic [CPSR_W-1:0]     alu_cpsr_out,
  output logic                  mem_fault
);

  mem_state_e state_q, state_d;

  logic [DATA_W-1:0]     addr_q, wdata_q;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [1:0]            ctrl_wb_q;
  logic [CPSR_W-1:0]     cpsr_q;

  logic [DATA_W-1:0]     wb_data_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [1:0]            wb_ctrl_q;
  logic [CPSR_W-1:0]     wb_cpsr_q;
  logic                  fault_q;

  logic mem_op, stall, complete, load_done, abort, timeout_hit;

  assign mem_op = ctrl_MEM_read_in | ctrl_MEM_write_in;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .busy_i    (state_q != IDLE),
    .expired_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A completing access releases the stall in the same cycle so upstream advances at that edge.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    complete  = 1'b0;
    load_done = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dmem.dmem_gnt && we_q) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          stall = 1'b1;
          if (dmem.dmem_gnt) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (dmem.dmem_rvalid) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_d   = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit && !complete && (state_q != IDLE)) begin
      abort   = 1'b1;
      stall   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      ctrl_wb_q <= WB_BUBBLE;
      cpsr_q    <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_ctrl_q <= WB_BUBBLE;
      wb_cpsr_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      fault_q <= abort;
      if (state_q == IDLE) begin
        if (mem_op) begin
          // A simultaneous read and write is issued as a read.
          addr_q    <= alu_result_in;
          wdata_q   <= rs2_data_in;
          we_q      <= ctrl_MEM_write_in & ~ctrl_MEM_read_in;
          rd_q      <= rd_addr_in;
          ctrl_wb_q <= ctrl_WB_in;
          cpsr_q    <= alu_cpsr_in;
          wb_ctrl_q <= WB_BUBBLE;
        end else begin
          wb_data_q <= alu_result_in;
          wb_rd_q   <= rd_addr_in;
          wb_ctrl_q <= ctrl_WB_in;
          wb_cpsr_q <= alu_cpsr_in;
        end
      end else if (complete) begin
        wb_data_q <= load_done ? dmem.dmem_rdata : addr_q;
        wb_rd_q   <= rd_q;
        wb_ctrl_q <= ctrl_wb_q;
        wb_cpsr_q <= cpsr_q;
      end else if (abort) begin
        wb_rd_q   <= rd_q;
        wb_cpsr_q <= cpsr_q;
        wb_ctrl_q <= WB_BUBBLE;
      end else begin
        wb_ctrl_q <= WB_BUBBLE;
      end
    end
  end

  assign stall_out       = stall & reset_n;
  assign dmem.dmem_req   = (state_q == REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign wb_data_out    = wb_data_q;
  assign wb_rd_addr_out = wb_rd_q;
  assign ctrl_WB_out    = wb_ctrl_q;
  assign alu_cpsr_out   = wb_cpsr_q;
  assign mem_fault      = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected writebacks plus
// per-scenario bus, stall and reset checks (timeout scenario under MEM_TIMEOUT_EN).
module tb_mem_stage;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  rd;
    logic [1:0]  ctrl;
    logic [6:0]  cpsr;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] aluResult, rs2Data;
  logic        memRead, memWrite;
  logic [1:0]  ctrlWb;
  logic [2:0]  rdAddr;
  logic [6:0]  aluCpsr;
  logic        stallOut;
  logic [15:0] wbData;
  logic [2:0]  wbRd;
  logic [1:0]  wbCtrl;
  logic [6:0]  wbCpsr;
  logic        memFault;

  int      checks = 0;
  int      errors = 0;
  wb_exp_t sbQ[$];

  mem_stage_if memIf ();

`ifdef MEM_TIMEOUT_EN
  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
`else
  mem_stage dut (
`endif
    .clk               (clk),
    .reset_n           (reset_n),
    .alu_result_in     (aluResult),
    .rs2_data_in       (rs2Data),
    .ctrl_MEM_read_in  (memRead),
    .ctrl_MEM_write_in (memWrite),
    .ctrl_WB_in        (ctrlWb),
    .rd_addr_in        (rdAddr),
    .alu_cpsr_in       (aluCpsr),
    .stall_out         (stallOut),
    .dmem              (memIf),
    .wb_data_out       (wbData),
    .wb_rd_addr_out    (wbRd),
    .ctrl_WB_out       (wbCtrl),
    .alu_cpsr_out      (wbCpsr),
    .mem_fault         (memFault)
  );

  always #5 clk = ~clk;

  // Every valid writeback must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wbCtrl !== 2'b00) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: got data=%h rd=%0d ctrl=%b, none expected", wbData, wbRd, wbCtrl);
      end else begin
        wb_exp_t exp;
        exp = sbQ.pop_front();
        if ({wbData, wbRd, wbCtrl, wbCpsr} !== exp) begin
          errors++;
          $display("[TB] FAIL sb_writeback: got data=%h rd=%0d ctrl=%b cpsr=%h, want data=%h rd=%0d ctrl=%b cpsr=%h",
                   wbData, wbRd, wbCtrl, wbCpsr, exp.data, exp.rd, exp.ctrl, exp.cpsr);
        end
      end
    end
  end

  task automatic drive_idle();
    aluResult = '0; rs2Data = '0; memRead = 1'b0; memWrite = 1'b0;
    ctrlWb = 2'b00; rdAddr = '0; aluCpsr = '0;
    memIf.dmem_gnt = 1'b0; memIf.dmem_rvalid = 1'b0; memIf.dmem_rdata = '0;
  endtask

  // Drives one memory op (holding it while stalled) and acts as the memory.
  task automatic run_access(
    input  logic isRead, isWrite,
    input  logic [15:0] addr, wdata,
    input  logic [2:0] rd, input logic [1:0] ctrl, input logic [6:0] cpsr,
    input  int gntWait, rvalidWait,
    input  logic [15:0] rdata, input logic spurious,
    output int stallCycles, reqCycles,
    output logic weSeen, addrStable,
    output logic [15:0] addrSeen, wdataSeen);
    int reqSeen, respSeen, cyc;
    logic granted, done;
    aluResult = addr; rs2Data = wdata; memRead = isRead; memWrite = isWrite;
    rdAddr = rd; ctrlWb = ctrl; aluCpsr = cpsr;
    memIf.dmem_gnt = 1'b0; memIf.dmem_rvalid = 1'b0;
    #1;
    stallCycles = stallOut ? 1 : 0;
    reqCycles = 0; weSeen = 1'b0; addrStable = 1'b1; addrSeen = '0; wdataSeen = '0;
    reqSeen = 0; respSeen = 0; granted = 1'b0; done = !stallOut; cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      memIf.dmem_gnt = 1'b0; memIf.dmem_rvalid = 1'b0; memIf.dmem_rdata = '0;
      if (memIf.dmem_req) begin
        if (reqCycles > 0 && memIf.dmem_addr !== addrSeen) addrStable = 1'b0;
        reqCycles++;
        weSeen    = weSeen | memIf.dmem_we;
        addrSeen  = memIf.dmem_addr;
        wdataSeen = memIf.dmem_wdata;
        if (reqSeen == gntWait) begin
          memIf.dmem_gnt = 1'b1;
          granted = 1'b1;
          if (spurious) begin
            memIf.dmem_rvalid = 1'b1;
            memIf.dmem_rdata  = 16'hDEAD;
          end
        end
        reqSeen++;
      end else if (granted) begin
        if (respSeen == rvalidWait) begin
          memIf.dmem_rvalid = 1'b1;
          memIf.dmem_rdata  = rdata;
        end
        respSeen++;
      end
      #1;
      if (stallOut) stallCycles++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL access_timeout: stall still %b after %0d cycles, want release", stallOut, cyc);
    end
    @(negedge clk);
    drive_idle();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    memRead = 1'b1; aluResult = 16'h0099;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stallOut, memIf.dmem_req, wbData, wbRd, wbCtrl, wbCpsr, memFault} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: stall=%b req=%b data=%h rd=%0d ctrl=%b cpsr=%h fault=%b, want all 0",
               stallOut, memIf.dmem_req, wbData, wbRd, wbCtrl, wbCpsr, memFault);
    end
    drive_idle();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_pass();
    aluResult = 16'h1234; rdAddr = 3'd5; ctrlWb = 2'b01; aluCpsr = 7'h2A;
    sbQ.push_back('{16'h1234, 3'd5, 2'b01, 7'h2A});
    #1;
    checks++;
    if (stallOut !== 1'b0) begin
      errors++; $display("[TB] FAIL alu_stall1: got %b want 0", stallOut);
    end
    @(negedge clk);
    checks++;
    if (wbData !== 16'h1234 || wbRd !== 3'd5) begin
      errors++; $display("[TB] FAIL alu_latency: got data=%h rd=%0d want 1234/5", wbData, wbRd);
    end
    aluResult = 16'hFFFF; rdAddr = 3'd7; ctrlWb = 2'b11; aluCpsr = 7'h7F;
    sbQ.push_back('{16'hFFFF, 3'd7, 2'b11, 7'h7F});
    #1;
    checks++;
    if (stallOut !== 1'b0) begin
      errors++; $display("[TB] FAIL alu_stall2: got %b want 0", stallOut);
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_load();
    int st, rq; logic we, stable; logic [15:0] a, wd;
    sbQ.push_back('{16'hBEEF, 3'd3, 2'b10, 7'h15});
    run_access(1'b1, 1'b0, 16'h0040, 16'h1111, 3'd3, 2'b10, 7'h15, 2, 0, 16'hBEEF, 1'b1,
               st, rq, we, stable, a, wd);
    checks++;
    if (st !== 4) begin errors++; $display("[TB] FAIL load_stall: got %0d want 4", st); end
    checks++;
    if (rq !== 3 || we !== 1'b0 || a !== 16'h0040 || stable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_bus: reqCycles=%0d we=%b addr=%h stable=%b want 3/0/0040/1", rq, we, a, stable);
    end
  endtask

  task automatic test_store();
    int st, rq; logic we, stable; logic [15:0] a, wd;
    sbQ.push_back('{16'h0010, 3'd1, 2'b01, 7'h03});
    run_access(1'b0, 1'b1, 16'h0010, 16'hA5A5, 3'd1, 2'b01, 7'h03, 0, 0, 16'h0000, 1'b0,
               st, rq, we, stable, a, wd);
    checks++;
    if (st !== 1) begin errors++; $display("[TB] FAIL store_stall: got %0d want 1", st); end
    checks++;
    if (rq !== 1 || we !== 1'b1 || a !== 16'h0010 || wd !== 16'hA5A5) begin
      errors++;
      $display("[TB] FAIL store_bus: reqCycles=%0d we=%b addr=%h wdata=%h want 1/1/0010/A5A5", rq, we, a, wd);
    end
    checks++;
    if (memFault !== 1'b0) begin errors++; $display("[TB] FAIL store_fault: got %b want 0", memFault); end
  endtask

  task automatic test_read_write();
    int st, rq; logic we, stable; logic [15:0] a, wd;
    sbQ.push_back('{16'h0C0C, 3'd6, 2'b10, 7'h11});
    run_access(1'b1, 1'b1, 16'h0077, 16'h5555, 3'd6, 2'b10, 7'h11, 0, 1, 16'h0C0C, 1'b0,
               st, rq, we, stable, a, wd);
    checks++;
    if (we !== 1'b0 || a !== 16'h0077) begin
      errors++; $display("[TB] FAIL rw_as_read: we=%b addr=%h want 0/0077", we, a);
    end
    checks++;
    if (st !== 3) begin errors++; $display("[TB] FAIL rw_stall: got %0d want 3", st); end
  endtask

  task automatic test_back_to_back();
    int st, rq; logic we, stable; logic [15:0] a, wd;
    sbQ.push_back('{16'h0123, 3'd2, 2'b01, 7'h01});
    run_access(1'b0, 1'b1, 16'h0123, 16'h4444, 3'd2, 2'b01, 7'h01, 1, 0, 16'h0000, 1'b0,
               st, rq, we, stable, a, wd);
    checks++;
    if (st !== 2) begin errors++; $display("[TB] FAIL b2b_store_stall: got %0d want 2", st); end
    checks++;
    if (memIf.dmem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_idle_gap: req=%b want 0", memIf.dmem_req);
    end
    sbQ.push_back('{16'h7E57, 3'd4, 2'b10, 7'h40});
    run_access(1'b1, 1'b0, 16'h0124, 16'h0000, 3'd4, 2'b10, 7'h40, 0, 2, 16'h7E57, 1'b0,
               st, rq, we, stable, a, wd);
    checks++;
    if (st !== 4 || rq !== 1) begin
      errors++; $display("[TB] FAIL b2b_load: stall=%0d reqCycles=%0d want 4/1", st, rq);
    end
  endtask

  task automatic test_reset_in_resp();
    aluResult = 16'h0080; memRead = 1'b1; rdAddr = 3'd1; ctrlWb = 2'b10;
    @(negedge clk);
    memIf.dmem_gnt = 1'b1;
    @(negedge clk);
    memIf.dmem_gnt = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({stallOut, memIf.dmem_req, wbData, wbRd, wbCtrl, wbCpsr} !== '0) begin
      errors++;
      $display("[TB] FAIL resp_reset: stall=%b req=%b data=%h rd=%0d ctrl=%b, want all 0",
               stallOut, memIf.dmem_req, wbData, wbRd, wbCtrl);
    end
    drive_idle();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    aluResult = 16'h0042;
    memIf.dmem_rvalid = 1'b1;
    memIf.dmem_rdata  = 16'hFFFF;
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (wbData !== 16'h0042 || wbCtrl !== 2'b00 || memIf.dmem_req !== 1'b0 || stallOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL late_rvalid: data=%h ctrl=%b req=%b stall=%b want 0042/00/0/0",
               wbData, wbCtrl, memIf.dmem_req, stallOut);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int st, rq; logic we, stable; logic [15:0] a, wd;
    run_access(1'b1, 1'b0, 16'h0200, 16'h0000, 3'd5, 2'b10, 7'h0F, 99, 0, 16'h0000, 1'b0,
               st, rq, we, stable, a, wd);
    checks++;
    if (rq !== 4 || st !== 4) begin
      errors++; $display("[TB] FAIL timeout_len: reqCycles=%0d stall=%0d want 4/4", rq, st);
    end
    checks++;
    if (memFault !== 1'b1 || wbCtrl !== 2'b00 || stallOut !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_abort: fault=%b ctrl=%b stall=%b want 1/00/0", memFault, wbCtrl, stallOut);
    end
    @(negedge clk);
    checks++;
    if (memFault !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pulse: fault=%b want 0", memFault); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_pass();
    test_load();
    test_store();
    test_read_write();
    test_back_to_back();
    test_reset_in_resp();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sbQ.size() != 0) begin
      errors++; $display("[TB] FAIL sb_leftover: %0d writebacks never seen, want 0", sbQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage directly downstream of the EX/MEM pipeline register. It consumes the registered ALU result, store data, memory controls, WB controls, destination address and CPSR flags. It performs data-memory reads and writes over a req/gnt/rvalid handshake and stalls the upstream pipeline while an access is outstanding. Its registered outputs feed the MEM/WB boundary.

Parameters:
DATA_W, 16, data and address width
REG_ADDR_W, 3, register-file address width
CPSR_W, 7, ALU flag width
TIMEOUT_CYCLES, 16, abort threshold; used only with MEM_TIMEOUT_EN

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
alu_result_in  in  16  ALU result; memory address for loads and stores
rs2_data_in  in  16  store data
ctrl_MEM_read_in  in  1  load request
ctrl_MEM_write_in  in  1  store request
ctrl_WB_in  in  2  writeback controls, passed through
rd_addr_in  in  3  destination register
alu_cpsr_in  in  7  flags, passed through
stall_out  out  1  high: upstream (EX/MEM write_enable) must hold
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  16  word address
dmem_wdata  out  16  write data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  16  read data
wb_data_out  out  16  load data or ALU result
wb_rd_addr_out  out  3  destination register
ctrl_WB_out  out  2  writeback controls; 0 = bubble
alu_cpsr_out  out  7  flags
mem_fault  out  1  one-cycle pulse on aborted access

Behaviour:
- Reset: one clock, asynchronous active-low reset. While reset_n = 0:
  - all outputs are 0 and the FSM is in IDLE
  - dmem_req drops immediately
  - a reset during REQ or RESP abandons the access; a late dmem_rvalid arriving in IDLE is ignored
- FSM states: IDLE, REQ, RESP.
- IDLE, no memory op (read = 0, write = 0):
  - stall_out = 0
  - at the next edge, wb_data_out <= alu_result_in; rd_addr, ctrl_WB and cpsr are registered through
  - latency 1 cycle
- IDLE, memory op present:
  - stall_out = 1 (combinational)
  - at the edge, latch address, wdata and the op into internal registers; go to REQ
  - the pipeline outputs take a bubble (ctrl_WB_out <= 0)
- Read and write both asserted: treated as a read; the write is ignored.
- REQ:
  - dmem_req = 1, with dmem_we, dmem_addr and dmem_wdata driven from the internal registers, stable until gnt
  - store with gnt = 1: completion cycle; go to IDLE
  - load with gnt = 1: go to RESP
  - gnt = 0: remain in REQ
- RESP:
  - dmem_req = 0
  - rvalid = 1: completion cycle; wb_data_out <= dmem_rdata; go to IDLE
  - rvalid is sampled only in RESP; an rvalid arriving in the gnt cycle is ignored
- Completion cycle:
  - stall_out = 0, so upstream advances at the same edge
  - at that edge, the latched rd_addr, ctrl_WB and cpsr are registered out
  - for a store, wb_data_out <= the latched ALU result
- Every non-completion stalled edge drives ctrl_WB_out <= 0, so WB never sees a duplicate.
- Minimum latency, with gnt and rvalid each at their first opportunity:
  - store: 2 cycles (IDLE, REQ)
  - load: 3 cycles (IDLE, REQ, RESP)
- Back-to-back memory ops: each returns to IDLE for one cycle before the next REQ.
- Address: 16-bit word address passed unchanged; no wrap or alignment logic.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - a counter clears on entry to REQ and increments each cycle in REQ or RESP
  - when the count reaches TIMEOUT_CYCLES - 1 without completion, the access is aborted: the FSM goes to IDLE, the cycle is treated as a completion with ctrl_WB_out <= 0, and mem_fault pulses high for 1 cycle
  - a completion on the threshold cycle wins over the abort; no fault is raised
- Undefined: the FSM waits indefinitely and mem_fault is tied to 0.

Decomposition:
- Shared package cpu_pkg: DATA_W, REG_ADDR_W, CPSR_W, the mem-stage state enum (IDLE, REQ, RESP), and the WB control-field encodings.
- One sub-module, mem_timeout_ctr: counter plus threshold compare; instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Non-mem op, alu_result = 0x1234, rd = 5, ctrl_WB = 2'b01 -> next cycle wb_data_out = 0x1234, wb_rd_addr_out = 5, stall_out never high.
- Load, addr 0x0040, gnt after 2 wait cycles, rvalid 1 cycle later with rdata 0xBEEF -> stall high for 4 cycles; dmem_addr = 0x0040 held with dmem_we = 0; wb_data_out = 0xBEEF with ctrl_WB valid exactly once.
- Store, addr 0x0010, data 0xA5A5, immediate gnt -> dmem_we = 1 with wdata 0xA5A5 for 1 cycle; stall for 1 cycle; 2-cycle total.
- Read and write both high -> read issued (dmem_we = 0); no write observed on the bus.
- reset_n low while in RESP, then rvalid pulses -> outputs 0, dmem_req 0, FSM in IDLE; the late rvalid is ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, gnt never asserted -> abort after 4 cycles in REQ; mem_fault high 1 cycle; ctrl_WB_out = 0; stall released.
